// File: rtl/ice40_spi_bus_arbiter_pkg.sv
// Shared definitions for the iCE40 SB_SPI system-bus arbiter: arbiter state
// encodings, SB_SPI register addresses and the latched bus-access record.
package ice40_spi_bus_arbiter_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ICE40_ARB_IDLE   = 2'd0,  // no owner
        ICE40_ARB_ACCESS = 2'd1,  // bus cycle in flight
        ICE40_ARB_DONE   = 2'd2,  // one-cycle acknowledge
        ICE40_ARB_HOLD   = 2'd3   // locked owner, nothing pending
    } arb_state_t;

    // SB_SPI hard-IP register addresses (SBADRi).
    typedef enum logic [7:0] {
        SPICR0  = 8'h08,
        SPICR1  = 8'h09,
        SPICR2  = 8'h0A,
        SPIBR   = 8'h0B,
        SPISR   = 8'h0C,
        SPITXDR = 8'h0D,
        SPIRXDR = 8'h0E,
        SPICSR  = 8'h0F
    } spi_reg_t;

    // One bus access as presented to the SB_SPI port.
    typedef struct packed {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
    } spi_access_t;

endpackage

// File: rtl/ice40_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at or
// after (last+1) mod N. Shared by arbiters in front of iCE40 hard IP ports.
module ice40_rr_pick #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] pick,
    output logic         any
);

    logic [W-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest requester after 'last' is written last and wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        pick = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = N; k >= 1; k--) begin
            cand = W'((int'(last) + k) % N);
            if (req[cand]) begin
                pick = cand;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ice40_spi_bus_arbiter.sv
// Round-robin arbiter sharing one SB_SPI system-bus port among N_REQ
// requesters, with bus locking across accesses and an acknowledge watchdog.
module ice40_spi_bus_arbiter
    import ice40_spi_bus_arbiter_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_strobe,
    input  logic [N_REQ-1:0]           req_rw,
    input  logic [8*N_REQ-1:0]         req_addr,
    input  logic [8*N_REQ-1:0]         req_wdata,
    input  logic [N_REQ-1:0]           req_lock,
    output logic [N_REQ-1:0]           req_ack,
    output logic [N_REQ-1:0]           req_err,
    output logic [7:0]                 req_rdata,
    output logic                       spi_strobe,
    output logic                       spi_rw,
    output logic [7:0]                 spi_reg_addr,
    output logic [7:0]                 spi_data_in,
    input  logic                       spi_ack,
    input  logic [7:0]                 spi_data_out,
    output logic                       grant_valid,
    output logic [$clog2(N_REQ)-1:0]   grant_id
);

    localparam int GW    = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    arb_state_t        state, state_d;
    logic [GW-1:0]     last_grant, last_d;
    logic [GW-1:0]     gid_d;
    logic              gv_d;
    logic              strobe_d;
    spi_access_t       bus_d;
    logic [N_REQ-1:0]  ack_d, err_d;
    logic [7:0]        rdata_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              timed_out, to_d;

    logic [GW-1:0]     pick_id;
    logic              pick_any;
    logic [GW-1:0]     sel_id;
    spi_access_t       sel_bus;
    logic [7:0]        addr_lane  [N_REQ];
    logic [7:0]        wdata_lane [N_REQ];

    // Unpack the per-requester byte lanes so they can be selected by id.
    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign addr_lane[i]  = req_addr[8*i +: 8];
        assign wdata_lane[i] = req_wdata[8*i +: 8];
    end

    ice40_rr_pick #(
        .N (N_REQ),
        .W (GW)
    ) u_pick (
        .req  (req_strobe),
        .last (last_grant),
        .pick (pick_id),
        .any  (pick_any)
    );

    // A locked owner re-issues its own fields; otherwise the round-robin winner's fields are taken.
    assign sel_id  = (state == ICE40_ARB_HOLD) ? grant_id : pick_id;
    assign sel_bus = '{rw: req_rw[sel_id], addr: addr_lane[sel_id], wdata: wdata_lane[sel_id]};

    // Next-state and next-output logic for the arbiter FSM.
    always_comb begin
        state_d  = state;
        last_d   = last_grant;
        gid_d    = grant_id;
        gv_d     = grant_valid;
        strobe_d = spi_strobe;
        bus_d    = '{rw: spi_rw, addr: spi_reg_addr, wdata: spi_data_in};
        ack_d    = '0;
        err_d    = '0;
        rdata_d  = req_rdata;
        cnt_d    = cnt;
        to_d     = timed_out;

        case (state)
            ICE40_ARB_IDLE: begin
                if (pick_any) begin
                    bus_d    = sel_bus;
                    strobe_d = 1'b1;
                    gv_d     = 1'b1;
                    gid_d    = pick_id;
                    last_d   = pick_id;
                    cnt_d    = '0;
                    to_d     = 1'b0;
                    state_d  = ICE40_ARB_ACCESS;
                end
            end

            ICE40_ARB_ACCESS: begin
                if (spi_ack) begin
                    strobe_d        = 1'b0;
                    rdata_d         = spi_data_out;
                    ack_d[grant_id] = 1'b1;
                    to_d            = 1'b0;
                    state_d         = ICE40_ARB_DONE;
                end else if (cnt == CNT_LIMIT) begin
                    strobe_d        = 1'b0;
                    rdata_d         = '0;
                    ack_d[grant_id] = 1'b1;
                    err_d[grant_id] = 1'b1;
                    to_d            = 1'b1;
                    state_d         = ICE40_ARB_DONE;
                end else if (cnt != CNT_MAX) begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            ICE40_ARB_DONE: begin
                // The grantee's strobe is still high here, so no strobe is looked at.
                if (!timed_out && req_lock[grant_id]) begin
                    state_d = ICE40_ARB_HOLD;
                end else begin
                    state_d = ICE40_ARB_IDLE;
                    gv_d    = 1'b0;
                end
            end

            ICE40_ARB_HOLD: begin
                if (req_strobe[grant_id]) begin
                    bus_d    = sel_bus;
                    strobe_d = 1'b1;
                    cnt_d    = '0;
                    to_d     = 1'b0;
                    state_d  = ICE40_ARB_ACCESS;
                end else if (!req_lock[grant_id]) begin
                    state_d = ICE40_ARB_IDLE;
                    gv_d    = 1'b0;
                end
            end

            default: state_d = ICE40_ARB_IDLE;
        endcase
    end

    // Register the FSM state together with every output, so no input reaches a port combinationally.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge; dropping spi_strobe here ends any in-flight access.
        if (reset) begin
            state        <= ICE40_ARB_IDLE;
            last_grant   <= GW'(N_REQ - 1);
            grant_id     <= '0;
            grant_valid  <= 1'b0;
            spi_strobe   <= 1'b0;
            spi_rw       <= 1'b0;
            spi_reg_addr <= '0;
            spi_data_in  <= '0;
            req_ack      <= '0;
            req_err      <= '0;
            req_rdata    <= '0;
            cnt          <= '0;
            timed_out    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state        <= state_d;
            last_grant   <= last_d;
            grant_id     <= gid_d;
            grant_valid  <= gv_d;
            spi_strobe   <= strobe_d;
            spi_rw       <= bus_d.rw;
            spi_reg_addr <= bus_d.addr;
            spi_data_in  <= bus_d.wdata;
            req_ack      <= ack_d;
            req_err      <= err_d;
            req_rdata    <= rdata_d;
            cnt          <= cnt_d;
            timed_out    <= to_d;
        end
    end

endmodule

// File: tb/tb_ice40_spi_bus_arbiter.sv
// Self-checking bench for ice40_spi_bus_arbiter: directed scenarios plus a
// randomized phase, checked against a transaction-level arbitration model.
module tb_ice40_spi_bus_arbiter;
    import ice40_spi_bus_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int T  = 8;
    localparam int GW = $clog2(N);

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_strobe, req_rw, req_lock;
    logic [8*N-1:0]  req_addr, req_wdata;
    logic [N-1:0]    req_ack, req_err;
    logic [7:0]      req_rdata;
    logic            spi_strobe, spi_rw, spi_ack;
    logic [7:0]      spi_reg_addr, spi_data_in, spi_data_out;
    logic            grant_valid;
    logic [GW-1:0]   grant_id;

    int checks   = 0;
    int failures = 0;

    // IP model configuration: ack this many cycles after the strobe rose (-1 = never).
    int         ack_delay = -1;
    logic [7:0] ip_rdata  = '0;

    // Arbitration model state.
    int model_last;
    int model_owner;
    bit model_hold;

    ice40_spi_bus_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_strobe   (req_strobe),
        .req_rw       (req_rw),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_lock     (req_lock),
        .req_ack      (req_ack),
        .req_err      (req_err),
        .req_rdata    (req_rdata),
        .spi_strobe   (spi_strobe),
        .spi_rw       (spi_rw),
        .spi_reg_addr (spi_reg_addr),
        .spi_data_in  (spi_data_in),
        .spi_ack      (spi_ack),
        .spi_data_out (spi_data_out),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    // SB_SPI model: acknowledges ack_delay cycles after the strobe rose; junk data otherwise.
    initial begin : ip_model
        int age;
        age          = 0;
        spi_ack      = 1'b0;
        spi_data_out = '0;
        forever begin
            @(negedge clk);
            if (spi_strobe === 1'b1) age++;
            else                     age = 0;
            spi_ack      = (ack_delay >= 0) && (age == ack_delay + 1);
            spi_data_out = spi_ack ? ip_rdata : 8'($urandom);
        end
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first pending requester at or after (last+1) mod N.
    function automatic int rr_expect(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    task automatic raise(input int id, input logic rw, input logic [7:0] a, input logic [7:0] wd);
        req_rw[id]           = rw;
        req_addr[8*id +: 8]  = a;
        req_wdata[8*id +: 8] = wd;
        req_strobe[id]       = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ":spi_strobe"},   32'(spi_strobe),   0);
        check({tag, ":spi_rw"},       32'(spi_rw),       0);
        check({tag, ":spi_reg_addr"}, 32'(spi_reg_addr), 0);
        check({tag, ":spi_data_in"},  32'(spi_data_in),  0);
        check({tag, ":req_ack"},      32'(req_ack),      0);
        check({tag, ":req_err"},      32'(req_err),      0);
        check({tag, ":req_rdata"},    32'(req_rdata),    0);
        check({tag, ":grant_valid"},  32'(grant_valid),  0);
        check({tag, ":grant_id"},     32'(grant_id),     0);
    endtask

    task automatic wait_rise(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (spi_strobe === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_ack(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (req_ack !== '0) begin
                n = i;
                break;
            end
        end
    endtask

    // One complete access from IDLE/HOLD: predict the winner, then check issue, completion and release.
    task automatic run_one(input int d, input logic [7:0] rd, input string tag);
        int w, n;
        bit to, lk;
        w  = model_hold ? model_owner : rr_expect(req_strobe, model_last);
        to = (d < 0);
        ack_delay = d;
        ip_rdata  = rd;

        wait_rise(4, n);
        check({tag, ":issue_lat"},   32'(n),            1);
        check({tag, ":grant_id"},    32'(grant_id),     32'(w));
        check({tag, ":grant_valid"}, 32'(grant_valid),  1);
        check({tag, ":spi_rw"},      32'(spi_rw),       32'(req_rw[w]));
        check({tag, ":spi_addr"},    32'(spi_reg_addr), 32'(req_addr[8*w +: 8]));
        check({tag, ":spi_wdata"},   32'(spi_data_in),  32'(req_wdata[8*w +: 8]));

        wait_ack(T + 6, n);
        check({tag, ":ack_lat"},     32'(n),            to ? 32'(T + 1) : 32'(d + 1));
        check({tag, ":req_ack"},     32'(req_ack),      32'(1) << w);
        check({tag, ":req_err"},     32'(req_err),      to ? (32'(1) << w) : 32'(0));
        check({tag, ":req_rdata"},   32'(req_rdata),    to ? 32'(0) : 32'(rd));
        check({tag, ":strobe_low"},  32'(spi_strobe),   0);

        lk = req_lock[w];
        req_strobe[w] = 1'b0;
        @(negedge clk);
        check({tag, ":ack_pulse"},   32'(req_ack),      0);
        check({tag, ":err_pulse"},   32'(req_err),      0);
        check({tag, ":gv_after"},    32'(grant_valid),  32'(lk && !to));

        model_last  = w;
        model_owner = w;
        model_hold  = lk && !to;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < N && req_strobe != '0; i++)
            run_one(int'($urandom_range(0, 3)), 8'($urandom), tag);
    endtask

    initial begin : main
        int n;
        reset      = 1'b1;
        req_strobe = '0;
        req_rw     = '0;
        req_lock   = '0;
        req_addr   = '0;
        req_wdata  = '0;
        model_last  = N - 1;
        model_owner = 0;
        model_hold  = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check("idle_quiet:strobe", 32'(spi_strobe), 0);

        // Single write from requester 0, acked 2 cycles after the strobe.
        raise(0, 1'b1, SPITXDR, 8'hA5);
        run_one(2, 8'h3C, "wr");

        // Read from requester 1, IP returns 0x10.
        raise(1, 1'b0, SPISR, 8'h00);
        run_one(1, 8'h10, "rd");

        // Round-robin: both requesters keep strobing with unlocked accesses.
        raise(0, 1'b1, SPITXDR, 8'h11);
        raise(1, 1'b0, SPISR,   8'h22);
        for (int i = 0; i < 4; i++) begin
            run_one(int'($urandom_range(0, 3)), 8'($urandom), "rr");
            for (int r = 0; r < N; r++)
                if (!req_strobe[r]) raise(r, 1'($urandom), 8'($urandom), 8'($urandom));
        end
        drain("rr_drain");

        // Lock: requester 0 reads then writes while requester 1 waits.
        req_lock[0] = 1'b1;
        raise(0, 1'b0, SPISR, 8'h00);
        run_one(int'($urandom_range(0, 3)), 8'h81, "lk_rd");
        raise(1, 1'b1, SPITXDR, 8'h55);
        raise(0, 1'b1, SPITXDR, 8'h77);
        run_one(int'($urandom_range(0, 3)), 8'h82, "lk_wr");
        repeat (3) begin
            @(negedge clk);
            check("lk_hold:grant_id", 32'(grant_id),    0);
            check("lk_hold:strobe",   32'(spi_strobe),  0);
        end
        req_lock[0] = 1'b0;
        @(negedge clk);
        check("lk_release:gv", 32'(grant_valid), 0);
        model_hold = 1'b0;
        run_one(int'($urandom_range(0, 3)), 8'h83, "lk_hand");

        // Timeout with the lock held: lock is ignored, next grant goes to requester 1.
        req_lock[0] = 1'b1;
        raise(0, 1'b0, SPISR, 8'h00);
        run_one(-1, 8'hFF, "to");
        req_lock[0] = 1'b0;
        raise(0, 1'b0, SPISR,   8'h00);
        raise(1, 1'b1, SPITXDR, 8'h99);
        run_one(1, 8'h44, "to_next");
        drain("to_drain");

        // Randomized mix of requests.
        for (int i = 0; i < 12; i++) begin
            for (int r = 0; r < N; r++)
                if (!req_strobe[r] && $urandom_range(0, 1) == 1)
                    raise(r, 1'($urandom), 8'($urandom), 8'($urandom));
            if (req_strobe == '0)
                raise(int'($urandom_range(0, N - 1)), 1'($urandom), 8'($urandom), 8'($urandom));
            run_one(int'($urandom_range(0, 4)), 8'($urandom), "rnd");
        end
        drain("rnd_drain");

        // Reset in the middle of an access.
        ack_delay = -1;
        raise(1, 1'b1, SPITXDR, 8'h5A);
        wait_rise(4, n);
        check("rst_mid:issue", 32'(n), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        raise(0, 1'b0, SPISR, 8'h00);
        @(negedge clk);
        check_zero("rst_mid");
        reset = 1'b0;
        model_last = N - 1;
        model_hold = 1'b0;
        run_one(1, 8'h66, "post_rst");
        run_one(2, 8'h67, "post_rst2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ice40_spi_bus_arbiter.md
# ice40_spi_bus_arbiter

Shares the single system-bus port of one iCE40 SB_SPI hard IP (strobe/rw/addr/data/ack) between `N_REQ` requesters, e.g. a master controller and a flash-status poller. Each requester sees the same strobe/ack protocol the hard IP presents. The arbiter grants accesses round-robin and lets a requester hold the bus across several accesses, such as a status poll followed by a TXDR write. A watchdog terminates accesses the IP never acknowledges. It sits between the requesters and the SB_SPI primitive.

## Interface
- `N_REQ`, default 2: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 255: maximum cycles in ACCESS without `spi_ack`, 1..65535.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `req_strobe` in N_REQ: per-requester access request; held until acked.
- `req_rw` in N_REQ: 1 = write, 0 = read.
- `req_addr` in 8·N_REQ: register address; requester i uses bits [8i+7:8i].
- `req_wdata` in 8·N_REQ: write data, packed the same way.
- `req_lock` in N_REQ: keep the grant after the current access completes.
- `req_ack` out N_REQ: one-cycle completion pulse to the grantee.
- `req_err` out N_REQ: high together with `req_ack` when the access timed out.
- `req_rdata` out 8: read data, shared by all requesters; valid while `req_ack` is high.
- `spi_strobe` out 1: SB_SPI SBSTBi.
- `spi_rw` out 1: SB_SPI SBRWi.
- `spi_reg_addr` out 8: SB_SPI SBADRi.
- `spi_data_in` out 8: SB_SPI SBDATi.
- `spi_ack` in 1: SB_SPI SBACKO.
- `spi_data_out` in 8: SB_SPI SBDATo.
- `grant_valid` out 1: a requester currently owns the bus.
- `grant_id` out $clog2(N_REQ): current or last owner.

## Operation
- States:
  - IDLE: no owner.
  - ACCESS: a bus cycle is in flight.
  - DONE: one-cycle acknowledge.
  - HOLD: owner has locked the bus and has no access pending.
- **IDLE.** If any `req_strobe` is high, pick the first requester at or after `(last_grant+1) mod N_REQ`. Then:
  - register its rw/addr/wdata onto the `spi_*` outputs;
  - set `spi_strobe`=1, `grant_valid`=1, `grant_id`=winner, `last_grant`=winner;
  - clear the timeout counter and go to ACCESS.
- **ACCESS.** `spi_*` outputs stay stable and the counter increments each cycle.
  - `spi_ack`=1: `spi_strobe`←0, `req_rdata`←`spi_data_out` (writes included), `req_ack[g]`←1, go to DONE.
  - Counter reaches `TIMEOUT_CYCLES` with no ack: `spi_strobe`←0, `req_rdata`←0, `req_ack[g]`←1, `req_err[g]`←1, go to DONE. The lock is ignored, so the next state is IDLE.
- **DONE.** `req_ack`/`req_err` return to 0 next cycle. All `req_strobe` inputs are ignored during DONE, because the grantee's strobe is still high here.
  - Normal completion with `req_lock[g]`=1: go to HOLD.
  - Otherwise: go to IDLE and set `grant_valid`←0.
- **HOLD.** Other requesters' strobes are ignored.
  - `req_strobe[g]`=1: latch its fields and go to ACCESS.
  - Otherwise, `req_lock[g]`=0: go to IDLE and set `grant_valid`←0.
  - If both are high, the strobe wins.
- Requester inputs are sampled only in IDLE and HOLD. Changes during ACCESS have no effect.
- Reset, including mid-access: state IDLE, `last_grant`=N_REQ−1 (requester 0 has first priority), counter 0. All outputs are 0: `spi_*`, `req_ack`, `req_err`, `req_rdata`, `grant_valid`, `grant_id`. The hard IP ends any in-flight strobe because `spi_strobe` drops.

## Timing
- Request high in cycle 0 from IDLE → `spi_strobe` high in cycle 1.
- `spi_ack` high in cycle k → `req_ack` high in cycle k+1 only, `spi_strobe` low in cycle k+1.
- `spi_strobe` is never high in two consecutive accesses without at least one low cycle (DONE).
- Minimum access-to-access spacing is 3 cycles for a locked owner and 3 cycles for a handover.
- Timeout: `req_err` asserts exactly `TIMEOUT_CYCLES`+1 cycles after `spi_strobe` rose.
- Counter width is $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.
- All outputs are registered. There is no combinational path from `req_*` or `spi_ack` to any output.

## Structure
- SB_SPI register address macros (`SPICR0`…`SPICSR`) stay in the shared `spi/ice40_spi.vh`.
- Add the arbiter state encodings there as `ICE40_ARB_*`.
- One sub-module, `ice40_rr_pick`: combinational round-robin picker. Inputs `req[N-1:0]`, `last[$clog2(N)-1:0]`; outputs `pick`, `any`. Reusable for other shared hard-IP ports (I2C, SPRAM).

## Test plan
- **Single write.** Requester 0 writes addr 0x0D, data 0xA5; IP model acks 2 cycles after strobe. Required: `spi_reg_addr`=0x0D, `spi_data_in`=0xA5, `spi_rw`=1; `req_ack[0]` pulses once; `req_err`=0.
- **Read.** Requester 1 reads 0x0C; IP returns 0x10. Required: `req_rdata`=0x10 in the `req_ack[1]` cycle.
- **Round-robin.** Both requesters strobe continuously with unlocked accesses. Required: grants alternate 0,1,0,1; neither requester waits more than one foreign access.
- **Lock.** Requester 0 holds `req_lock`, reads 0x0C, then writes 0x0D while requester 1 is strobing. Required: both accesses complete before `grant_id` changes to 1.
- **Timeout.** `TIMEOUT_CYCLES`=8 and the IP never acks. Required: `req_ack[0]` and `req_err[0]` high together 9 cycles after the strobe rose; `req_rdata`=0; the next grant goes to requester 1.
- **Reset mid-ACCESS.** Assert `reset` during ACCESS. Required: next cycle all outputs are 0; the first post-reset grant with both requesters strobing goes to requester 0.
